// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial receive scheduler.
//   ch_state_t : per-channel receive state (IDLE, SHIFT, FULL)
//   ch_id_w()  : width of a channel-id field for a given channel count
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } ch_state_t;

    function automatic int unsigned ch_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_scheduler_lane.sv
// rx_lane: one serial receive channel.
// Shifts in one WORD_W-bit word MSB-first on bit ticks while req is high,
// then holds it (full=1) until granted.
// Optional macro PARITY_CHECK_EN: a trailing even-parity bit follows the
// word; a mismatch drops the word and pulses parity_pulse.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   tick          : bit-rate enable
//   din, req      : serial data bit and frame-active level
//   grant         : arbiter has taken the held word
//   full          : a completed word is held
//   word          : shift register contents
//   abort_pulse   : one clk after a tick where req dropped mid-word
//   parity_pulse  : (PARITY_CHECK_EN) one clk after a bad parity bit
module rx_lane
    import serial_rx_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              din,
    input  logic              req,
    input  logic              grant,
    output logic              full,
    output logic [WORD_W-1:0] word,
    output logic              abort_pulse
`ifdef PARITY_CHECK_EN
    ,
    output logic              parity_pulse
`endif
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    ch_state_t         state;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            sr          <= '0;
            abort_pulse <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_pulse <= 1'b0;
`endif
        end else begin
            abort_pulse <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (tick && req) begin
                        sr    <= {{(WORD_W-1){1'b0}}, din};
                        count <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!req) begin
                            state       <= IDLE;
                            count       <= '0;
                            sr          <= '0;
                            abort_pulse <= 1'b1;
                        end
`ifdef PARITY_CHECK_EN
                        else if (count == CNT_W'(WORD_W)) begin
                            // parity bit: word is complete, sr is not shifted
                            count <= '0;
                            if ((^sr) == din) begin
                                state <= FULL;
                            end else begin
                                state        <= IDLE;
                                sr           <= '0;
                                parity_pulse <= 1'b1;
                            end
                        end
`endif
                        else begin
                            sr    <= {sr[WORD_W-2:0], din};
                            count <= count + 1'b1;
`ifndef PARITY_CHECK_EN
                            if (count == LAST) state <= FULL;
`endif
                        end
                    end
                end
                FULL: begin
                    // tick, din and req are ignored until the word is taken
                    if (grant) begin
                        state <= IDLE;
                        count <= '0;
                        sr    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full = (state == FULL);
    assign word = sr;

endmodule

// File: rtl/serial_rx_scheduler.sv
// serial_rx_scheduler: multi-channel bit-serial receive controller.
// Generates a bit-rate enable, frames each channel's word capture through
// rx_lane, and round-robin arbitrates completed words into one
// valid/ready output register.
// Optional macro PARITY_CHECK_EN adds a per-frame even-parity bit and the
// parity_err port.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ch_din     : serial data, one bit per channel
//   ch_req     : frame-active level per channel
//   ch_busy    : channel holds a completed word awaiting grant
//   out_valid, out_ready, out_data, out_ch : output stream
//   abort_err  : one-clk pulse, some channel lost ch_req mid-word
//   bit_tick   : one-clk bit-rate strobe
//   parity_err : (PARITY_CHECK_EN) one-clk pulse on a parity mismatch
module serial_rx_scheduler
    import serial_rx_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned WORD_W  = 32,
    parameter  int unsigned CLK_DIV = 101,
    localparam int unsigned CH_W    = ch_id_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_din,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              abort_err,
    output logic              bit_tick
`ifdef PARITY_CHECK_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0]     tick_cnt;
    logic [NUM_CH-1:0] full_vec;
    logic [NUM_CH-1:0] abort_vec;
    logic [NUM_CH-1:0] grant_vec;
    logic [WORD_W-1:0] word_arr [NUM_CH];
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_id;
    logic              grant_any;
    logic              slot_free;
    logic [CH_W:0]     scan;
`ifdef PARITY_CHECK_EN
    logic [NUM_CH-1:0] parity_vec;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                            tick_cnt <= tick_cnt + 1'b1;
    end

    assign bit_tick = (tick_cnt == TICK_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        rx_lane #(.WORD_W(WORD_W)) u_lane (
            .clk         (clk),
            .reset       (reset),
            .tick        (bit_tick),
            .din         (ch_din[i]),
            .req         (ch_req[i]),
            .grant       (grant_vec[i]),
            .full        (full_vec[i]),
            .word        (word_arr[i]),
            .abort_pulse (abort_vec[i])
`ifdef PARITY_CHECK_EN
            ,
            .parity_pulse(parity_vec[i])
`endif
        );
    end

    assign slot_free = !out_valid || out_ready;

    // First FULL channel at or after the pointer, scanning with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_vec = '0;
        scan      = '0;
        if (slot_free) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                scan = {1'b0, ptr} + (CH_W+1)'(k);
                if (scan >= (CH_W+1)'(NUM_CH)) scan = scan - (CH_W+1)'(NUM_CH);
                if (!grant_any && full_vec[scan[CH_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = scan[CH_W-1:0];
                end
            end
        end
        if (grant_any) grant_vec[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (grant_any) begin
            out_valid <= 1'b1;
            out_data  <= word_arr[grant_id];
            out_ch    <= grant_id;
            ptr       <= (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ch_busy   = full_vec;
    assign abort_err = |abort_vec;
`ifdef PARITY_CHECK_EN
    assign parity_err = |parity_vec;
`endif

endmodule

// File: tb/tb_serial_rx_scheduler.sv
// Self-checking bench for serial_rx_scheduler (NUM_CH=4, WORD_W=32,
// CLK_DIV=4). Honours PARITY_CHECK_EN when defined.
module tb_serial_rx_scheduler;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CH_W    = 2;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME_BITS = WORD_W + 1;
`else
    localparam int unsigned FRAME_BITS = WORD_W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_din;
    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_busy;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              abort_err;
    logic              bit_tick;
`ifdef PARITY_CHECK_EN
    logic              parity_err;
`endif

    serial_rx_scheduler #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_din    (ch_din),
        .ch_req    (ch_req),
        .ch_busy   (ch_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .abort_err (abort_err),
        .bit_tick  (bit_tick)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [WORD_W-1:0] data;
    } item_t;

    typedef struct {
        int unsigned       ch;
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] exp_data;
        logic [CH_W-1:0]   exp_ch;
    } vec_t;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned abort_cnt  = 0;
    int unsigned parity_cnt = 0;
    item_t       got_q [$];
    item_t       exp_q [$];
    logic [WORD_W-1:0] tx_word [NUM_CH];
    logic        rand_ready = 1'b0;

    logic              stall_prev = 1'b0;
    logic [WORD_W-1:0] hold_data;
    logic [CH_W-1:0]   hold_ch;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bit b of a frame: word bits MSB-first, then the even-parity bit.
    function automatic logic frame_bit(input logic [WORD_W-1:0] w, input int unsigned b,
                                       input logic flip);
        logic [WORD_W-1:0] s;
        if (b < WORD_W) begin
            s = w << b;
            return s[WORD_W-1];
        end
        return (^w) ^ flip;
    endfunction

    // Returns at the falling edge of a tick cycle; the next rising edge samples.
    task automatic wait_tick();
        int unsigned guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bit_tick && guard <= 2 * CLK_DIV);
        if (!bit_tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=no_tick required=tick");
        end
    endtask

    task automatic send_frames(input logic [NUM_CH-1:0] mask, input int unsigned nbits,
                               input logic flip);
        logic [NUM_CH-1:0] d;
        for (int unsigned b = 0; b < nbits; b++) begin
            wait_tick();
            d = '0;
            for (int unsigned c = 0; c < NUM_CH; c++)
                if (mask[c]) d[c] = frame_bit(tx_word[c], b, flip);
            ch_din = d;
            ch_req = mask;
        end
    endtask

    // One clk after the last sampling tick.
    task automatic release_req();
        @(negedge clk);
        ch_req = '0;
        ch_din = '0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic wait_clks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, hold_data);
                check("hold_ch", out_ch, hold_ch);
            end
            if (out_valid && out_ready) got_q.push_back('{ch: out_ch, data: out_data});
            if (abort_err) abort_cnt++;
`ifdef PARITY_CHECK_EN
            if (parity_err) parity_cnt++;
`endif
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_ch    = out_ch;
        end
    end

    vec_t vecs [5];

    initial begin
        int unsigned n;
        int unsigned pos [NUM_CH];
        int unsigned cut [NUM_CH];
        int unsigned gap [NUM_CH];
        int unsigned exp_aborts;
        int          idx;
        logic [NUM_CH-1:0] d;
        logic [NUM_CH-1:0] r;
        logic        ab;

        vecs[0] = '{ch: 0, word: 32'hDEADBEEF, exp_data: 32'hDEADBEEF, exp_ch: 2'd0};
        vecs[1] = '{ch: 1, word: 32'hFFFFFFFF, exp_data: 32'hFFFFFFFF, exp_ch: 2'd1};
        vecs[2] = '{ch: 2, word: 32'h00000000, exp_data: 32'h00000000, exp_ch: 2'd2};
        vecs[3] = '{ch: 0, word: 32'h80000001, exp_data: 32'h80000001, exp_ch: 2'd0};
        vecs[4] = '{ch: 3, word: 32'h0000FFFF, exp_data: 32'h0000FFFF, exp_ch: 2'd3};

        reset     = 1'b1;
        ch_din    = '0;
        ch_req    = '0;
        out_ready = 1'b1;
        #23;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_ch", out_ch, '0);
        check("rst_busy", ch_busy, '0);
        check("rst_abort", abort_err, 1'b0);
        check("rst_tick", bit_tick, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Tick period and width.
        wait_tick();
        @(negedge clk);
        check("tick_width", bit_tick, 1'b0);
        n = 1;
        while (!bit_tick && n < 4 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("tick_period", n, CLK_DIV);

        // Single-channel words with latency: FULL 1 clk, out_valid 2 clk after last tick.
        for (int unsigned i = 0; i < 5; i++) begin
            tx_word[vecs[i].ch] = vecs[i].word;
            send_frames(NUM_CH'(1) << vecs[i].ch, FRAME_BITS, 1'b0);
            release_req();
            check("vec_busy", ch_busy, NUM_CH'(1) << vecs[i].ch);
            check("vec_early_valid", out_valid, 1'b0);
            @(negedge clk);
            check("vec_valid", out_valid, 1'b1);
            check("vec_data", out_data, vecs[i].exp_data);
            check("vec_ch", out_ch, vecs[i].exp_ch);
            check("vec_busy_clr", ch_busy, '0);
            @(negedge clk);
            check("vec_drop", out_valid, 1'b0);
        end

        // All four channels complete together: back-to-back in RR order.
        for (int unsigned c = 0; c < NUM_CH; c++) tx_word[c] = (c + 1) * 32'h11111111;
        send_frames('1, FRAME_BITS, 1'b0);
        release_req();
        check("all_busy", ch_busy, 4'b1111);
        check("all_early_valid", out_valid, 1'b0);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            @(negedge clk);
            check("all_valid", out_valid, 1'b1);
            check("all_ch", out_ch, k);
            check("all_data", out_data, (k + 1) * 32'h11111111);
            check("all_busy_clr", ch_busy, (4'b1111 << (k + 1)) & 4'b1111);
        end
        @(negedge clk);
        check("all_drop", out_valid, 1'b0);

        // Stall with ch2 pending; ch1 completes behind it; pointer wraps to ch1.
        set_ready(1'b0);
        got_q.delete();
        tx_word[2] = 32'hCAFEF00D;
        send_frames(4'b0100, FRAME_BITS, 1'b0);
        release_req();
        tx_word[1] = 32'h12345678;
        send_frames(4'b0010, FRAME_BITS, 1'b0);
        release_req();
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_data", out_data, 32'hCAFEF00D);
            check("stall_busy", ch_busy, 4'b0010);
        end
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("stall_next_ch", out_ch, 2'd1);
        check("stall_next_data", out_data, 32'h12345678);
        wait_clks(3);
        check("stall_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("stall_first", got_q[0].data, 32'hCAFEF00D);
            check("stall_second", got_q[1].data, 32'h12345678);
        end

        // Abort after 17 bits on ch3, then a clean frame.
        got_q.delete();
        abort_cnt = 0;
        tx_word[3] = 32'h0F0F0F0F;
        send_frames(4'b1000, 17, 1'b0);
        wait_tick();
        ch_req = '0;
        wait_clks(10);
        check("abort_pulses", abort_cnt, 1);
        check("abort_no_out", got_q.size(), 0);
        check("abort_busy", ch_busy, '0);
        tx_word[3] = 32'h0000FFFF;
        send_frames(4'b1000, FRAME_BITS, 1'b0);
        release_req();
        wait_clks(4);
        check("after_abort_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("after_abort_data", got_q[0].data, 32'h0000FFFF);
            check("after_abort_ch", got_q[0].ch, 2'd3);
        end
        // Two channels aborting on the same tick give one pulse.
        abort_cnt = 0;
        tx_word[0] = 32'hAAAA5555;
        tx_word[2] = 32'h5555AAAA;
        send_frames(4'b0101, 5, 1'b0);
        wait_tick();
        ch_req = '0;
        wait_clks(10);
        check("dual_abort_pulses", abort_cnt, 1);

        // Reset mid-word with a pending output.
        set_ready(1'b0);
        tx_word[0] = 32'hA5A5A5A5;
        send_frames(4'b0001, FRAME_BITS, 1'b0);
        release_req();
        wait_clks(3);
        check("pre_rst_valid", out_valid, 1'b1);
        tx_word[1] = 32'h5A5A1234;
        send_frames(4'b0010, 10, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, '0);
        check("mid_rst_ch", out_ch, '0);
        check("mid_rst_busy", ch_busy, '0);
        check("mid_rst_tick", bit_tick, 1'b0);
        ch_req = '0;
        ch_din = '0;
        @(negedge clk);
        reset = 1'b0;
        set_ready(1'b1);
        got_q.delete();
        send_frames(4'b0010, FRAME_BITS, 1'b0);
        release_req();
        wait_clks(4);
        check("post_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("post_rst_data", got_q[0].data, 32'h5A5A1234);
            check("post_rst_ch", got_q[0].ch, 2'd1);
        end

`ifdef PARITY_CHECK_EN
        got_q.delete();
        parity_cnt = 0;
        tx_word[0] = 32'h00000001;
        send_frames(4'b0001, FRAME_BITS, 1'b1);
        release_req();
        wait_clks(6);
        check("par_bad_pulse", parity_cnt, 1);
        check("par_bad_no_out", got_q.size(), 0);
        send_frames(4'b0001, FRAME_BITS, 1'b0);
        release_req();
        wait_clks(4);
        check("par_good_pulse", parity_cnt, 1);
        check("par_good_count", got_q.size(), 1);
        if (got_q.size() == 1) check("par_good_data", got_q[0].data, 32'h00000001);
`endif

        // Randomized traffic against a per-channel word-list model.
        got_q.delete();
        exp_q.delete();
        abort_cnt  = 0;
        exp_aborts = 0;
        rand_ready = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pos[c] = 0;
            cut[c] = FRAME_BITS;
            gap[c] = $urandom_range(0, 3);
        end
        for (int unsigned t = 0; t < 700; t++) begin
            wait_tick();
            d  = '0;
            r  = '0;
            ab = 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (pos[c] == 0) begin
                    if (gap[c] > 0) begin
                        gap[c]--;
                    end else if (t < 600 && !ch_busy[c] && $urandom_range(0, 1) == 0) begin
                        tx_word[c] = $urandom;
                        cut[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FRAME_BITS - 1)
                                                              : FRAME_BITS;
                        d[c]   = frame_bit(tx_word[c], 0, 1'b0);
                        r[c]   = 1'b1;
                        pos[c] = 1;
                    end
                end else if (pos[c] == cut[c]) begin
                    if (cut[c] < FRAME_BITS) ab = 1'b1;
                    else exp_q.push_back('{ch: CH_W'(c), data: tx_word[c]});
                    pos[c] = 0;
                    gap[c] = $urandom_range(1, 3);
                end else begin
                    d[c] = frame_bit(tx_word[c], pos[c], 1'b0);
                    r[c] = 1'b1;
                    pos[c]++;
                end
            end
            if (ab) exp_aborts++;
            ch_din = d;
            ch_req = r;
        end
        rand_ready = 1'b0;
        set_ready(1'b1);
        wait_clks(40);
        foreach (got_q[i]) begin
            idx = -1;
            foreach (exp_q[j]) if (idx < 0 && exp_q[j].ch == got_q[i].ch) idx = j;
            if (idx < 0) begin
                checks++;
                failures++;
                $display("FAIL rand_extra actual=ch%0d:%0h required=none", got_q[i].ch, got_q[i].data);
            end else begin
                check("rand_word", got_q[i].data, exp_q[idx].data);
                exp_q.delete(idx);
            end
        end
        check("rand_leftover", exp_q.size(), 0);
        check("rand_aborts", abort_cnt, exp_aborts);
        check("rand_idle_busy", ch_busy, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
